// File: rtl/grf_wb_ctrl_pkg.sv
// grf_wb_ctrl_pkg
// Shared definitions for the GRF write-port controller and the hazard unit:
// register-address width, the hard-wired zero register, the write-request
// record type and a helper that tells whether a destination really writes.
// No ports (package).
// Optional feature macro used by the files importing this package: WB_TRACE_EN.

package grf_wb_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int WB_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [WB_DW-1:0]  data;
    logic [31:0]       pc;
  } wb_req_t;

  // Writes to $0 are architecturally discarded, so they never count as requests.
  function automatic logic isRealDest(input logic [REG_AW-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/grf_wb_ctrl_tag.sv
// wb_tag_fifo
// Reservation FIFO of long-latency destinations, in issue order.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-low reset
//   i_push          - push request (accepted when not full, or when popping)
//   i_push_addr     - destination register to reserve
//   i_push_pc       - PC of the issuing instruction (WB_TRACE_EN builds only)
//   i_pop           - pop request (ignored when empty)
//   o_full/o_empty  - occupancy flags
//   o_head_addr     - destination of the oldest entry
//   o_head_pc       - PC of the oldest entry (WB_TRACE_EN builds only)
//   o_valid/o_addr  - per-slot valid bit and address, for the pending decode
// Macro: WB_TRACE_EN adds PC storage alongside each address.

module wb_tag_fifo
  import grf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [REG_AW-1:0]             i_push_addr,
`ifdef WB_TRACE_EN
  input  logic [31:0]                   i_push_pc,
  output logic [31:0]                   o_head_pc,
`endif
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [REG_AW-1:0]             o_head_addr,
  output logic [DEPTH-1:0]              o_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  o_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]                 r_wrPtr;
  logic [AW-1:0]                 r_rdPtr;
  logic [DEPTH-1:0]              r_valid;
  logic [DEPTH-1:0][REG_AW-1:0]  r_addr;
  logic                          w_doPop;
  logic                          w_doPush;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // When full, push and pop hit the same slot; the set below wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_valid <= '0;
    end else begin
      if (w_doPop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + 1'b1;
      end
      if (w_doPush) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_addr[r_wrPtr] <= i_push_addr;
    end
  end

`ifdef WB_TRACE_EN
  logic [DEPTH-1:0][31:0] r_pc;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_pc[r_wrPtr] <= i_push_pc;
    end
  end

  assign o_head_pc = r_pc[r_rdPtr];
`endif

  assign o_full      = &r_valid;
  assign o_empty     = ~|r_valid;
  assign o_head_addr = r_addr[r_rdPtr];
  assign o_valid     = r_valid;
  assign o_addr      = r_addr;

endmodule

// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl
// Sole driver of the GRF write port. Merges W-stage writebacks with in-order
// long-latency results, reserves destinations at issue and publishes a
// pending-register bitmap for the hazard unit.
// Ports:
//   clk, reset                       - rising-edge clock, synchronous active-low reset
//   w_we/w_addr/w_data/w_pc          - W-stage write request
//   lq_issue/lq_issue_addr/_pc       - long-latency issue, reserves a destination
//   lq_full                          - reservation FIFO holds DEPTH entries
//   lq_done_valid/lq_done_data       - oldest long-latency result offered
//   lq_done_ready                    - that result is accepted this cycle
//   grf_we/grf_a3/grf_wd             - registered GRF write port
//   pending                          - bit r set while r is reserved; bit 0 always 0
// Macro: WB_TRACE_EN registers the PC with each write and prints a trace line
// for every cycle with grf_we=1.

module grf_wb_ctrl
  import grf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [REG_AW-1:0] w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic [31:0]       w_pc,
  input  logic              lq_issue,
  input  logic [REG_AW-1:0] lq_issue_addr,
  input  logic [31:0]       lq_issue_pc,
  output logic              lq_full,
  input  logic              lq_done_valid,
  input  logic [DW-1:0]     lq_done_data,
  output logic              lq_done_ready,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DW-1:0]     grf_wd,
  output logic [31:0]       pending
);

  logic                          w_wReq;
  logic                          w_issue;
  logic                          w_pop;
  logic                          w_empty;
  logic [REG_AW-1:0]             w_headAddr;
  logic [DEPTH-1:0]              w_entryValid;
  logic [DEPTH-1:0][REG_AW-1:0]  w_entryAddr;
  logic [31:0]                   w_pending;

  logic                          r_we;
  logic [REG_AW-1:0]             r_a3;
  logic [DW-1:0]                 r_wd;

  // A W-stage write to a real register always owns the port; $0 leaves it free.
  assign w_wReq  = w_we && isRealDest(w_addr);
  assign w_issue = lq_issue && isRealDest(lq_issue_addr);
  assign w_pop   = lq_done_valid && !w_empty && !w_wReq;

  assign lq_done_ready = w_pop;

`ifdef WB_TRACE_EN
  logic [31:0] w_headPc;
  logic [31:0] r_pc;
`endif

  wb_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tagFifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_issue),
    .i_push_addr (lq_issue_addr),
`ifdef WB_TRACE_EN
    .i_push_pc   (lq_issue_pc),
    .o_head_pc   (w_headPc),
`endif
    .i_pop       (w_pop),
    .o_full      (lq_full),
    .o_empty     (w_empty),
    .o_head_addr (w_headAddr),
    .o_valid     (w_entryValid),
    .o_addr      (w_entryAddr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we <= 1'b0;
      r_a3 <= REG_ZERO;
      r_wd <= '0;
    end else if (w_wReq) begin
      r_we <= 1'b1;
      r_a3 <= w_addr;
      r_wd <= w_data;
    end else if (w_pop) begin
      r_we <= 1'b1;
      r_a3 <= w_headAddr;
      r_wd <= lq_done_data;
    end else begin
      r_we <= 1'b0;
      r_a3 <= REG_ZERO;
      r_wd <= '0;
    end
  end

  // Several entries may name the same register; any one of them keeps it pending.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entryValid[i]) begin
        w_pending[w_entryAddr[i]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  assign grf_we  = r_we;
  assign grf_a3  = r_a3;
  assign grf_wd  = r_wd;
  assign pending = w_pending;

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (w_wReq) begin
      r_pc <= w_pc;
    end else if (w_pop) begin
      r_pc <= w_headPc;
    end else begin
      r_pc <= '0;
    end
  end

  always @(posedge clk) begin
    if (r_we) begin
      $display("%0t@%08h: $%d <= %08h", $time, r_pc, r_a3, r_wd);
    end
  end
`else
  // The PC inputs only feed the trace; fold them here so they are visibly unused.
  logic w_unused;
  assign w_unused = ^{w_pc, lq_issue_pc};
`endif

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// tb_grf_wb_ctrl
// Drives grf_wb_ctrl with directed sequences followed by random traffic and
// compares every cycle against a queue-based reference of the write-port
// controller's behaviour.

module tb_grf_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_we;
  logic [4:0]    w_addr;
  logic [DW-1:0] w_data;
  logic [31:0]   w_pc;
  logic          lq_issue;
  logic [4:0]    lq_issue_addr;
  logic [31:0]   lq_issue_pc;
  logic          lq_full;
  logic          lq_done_valid;
  logic [DW-1:0] lq_done_data;
  logic          lq_done_ready;
  logic          grf_we;
  logic [4:0]    grf_a3;
  logic [DW-1:0] grf_wd;
  logic [31:0]   pending;

  int checks = 0;
  int errors = 0;

  // Reference state: outstanding reservations in issue order plus the
  // write expected on the port in the current cycle.
  int          resQ[$];
  bit          modelValid = 1'b0;
  bit          expWe;
  bit          expZero;
  int          expA3;
  logic [31:0] expWd;

  always #5 clk = ~clk;

  grf_wb_ctrl #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .w_we          (w_we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .w_pc          (w_pc),
    .lq_issue      (lq_issue),
    .lq_issue_addr (lq_issue_addr),
    .lq_issue_pc   (lq_issue_pc),
    .lq_full       (lq_full),
    .lq_done_valid (lq_done_valid),
    .lq_done_data  (lq_done_data),
    .lq_done_ready (lq_done_ready),
    .grf_we        (grf_we),
    .grf_a3        (grf_a3),
    .grf_wd        (grf_wd),
    .pending       (pending)
  );

  function automatic logic [31:0] modelPending();
    logic [31:0] p;
    p = '0;
    foreach (resQ[i]) p[resQ[i]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the DUT against the model, advance the model.
  task automatic applyStimulus(input bit rstN, input bit we, input logic [4:0] wa,
                               input logic [31:0] wd, input bit iss,
                               input logic [4:0] ia, input bit dv,
                               input logic [31:0] dd);
    bit wReq;
    bit expReady;
    int sizeBefore;
    @(negedge clk);
    reset         = rstN;
    w_we          = we;
    w_addr        = wa;
    w_data        = wd;
    w_pc          = $urandom;
    lq_issue      = iss;
    lq_issue_addr = ia;
    lq_issue_pc   = $urandom;
    lq_done_valid = dv;
    lq_done_data  = dd;
    #1;
    wReq     = we && (wa != 5'd0);
    expReady = dv && (resQ.size() > 0) && !wReq;
    if (modelValid) begin
      checkOutput("lq_done_ready", 32'(lq_done_ready), 32'(expReady));
      checkOutput("grf_we", 32'(grf_we), 32'(expWe));
      if (expWe || expZero) begin
        checkOutput("grf_a3", 32'(grf_a3), 32'(expA3));
        checkOutput("grf_wd", grf_wd, expWd);
      end
      checkOutput("pending", pending, modelPending());
      checkOutput("lq_full", 32'(lq_full), 32'(resQ.size() == DEPTH));
    end
    @(posedge clk);
    if (!rstN) begin
      resQ.delete();
      expWe      = 1'b0;
      expZero    = 1'b1;
      expA3      = 0;
      expWd      = '0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      expZero    = 1'b0;
      sizeBefore = resQ.size();
      if (wReq) begin
        expWe = 1'b1;
        expA3 = int'(wa);
        expWd = wd;
      end else if (expReady) begin
        expWe = 1'b1;
        expA3 = resQ[0];
        expWd = dd;
      end else begin
        expWe = 1'b0;
      end
      if (expReady) void'(resQ.pop_front());
      if (iss && ia != 5'd0 && (sizeBefore < DEPTH || expReady))
        resQ.push_back(int'(ia));
    end
  endtask

  initial begin
    reset         = 1'b0;
    w_we          = 1'b0;
    w_addr        = '0;
    w_data        = '0;
    w_pc          = '0;
    lq_issue      = 1'b0;
    lq_issue_addr = '0;
    lq_issue_pc   = '0;
    lq_done_valid = 1'b0;
    lq_done_data  = '0;

    // Reset held with a W write pending, then a plain W write.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 5, 32'h1111, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 32'h1234, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Single reservation and completion.
    applyStimulus(1, 0, 0, 0, 1, 8, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hABCD);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Completion collides with a W write, then goes through.
    applyStimulus(1, 0, 0, 0, 1, 7, 0, 0);
    applyStimulus(1, 1, 3, 32'h3333, 0, 0, 1, 32'h7777);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h7777);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Fill, drop an issue while full, then issue with a simultaneous pop and drain.
    for (int r = 1; r <= 4; r++) applyStimulus(1, 0, 0, 0, 1, 5'(r), 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 10, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 9, 1, 32'hD001);
    for (int r = 0; r < 4; r++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hD002 + r);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // $0 writes and issues are no-ops; a result with nothing reserved is ignored.
    applyStimulus(1, 0, 0, 0, 1, 6, 0, 0);
    applyStimulus(1, 1, 0, 32'hFFFF, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h5555);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h6666);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 149) != 0),
                    ($urandom_range(0, 2) == 0),
                    (($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom)),
                    $urandom,
                    ($urandom_range(0, 2) == 0),
                    (($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom)),
                    ($urandom_range(0, 1) == 0),
                    $urandom);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
